// File: rtl/prio_enc_stream.sv
// Sequential priority encoder: accepts a request vector and streams out the
// index of every set bit, one beat per handshake, in priority order.
module prio_enc_stream #(
  parameter int WIDTH     = 16,
  parameter int IDX_W     = $clog2(WIDTH),
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_none,
  output logic [IDX_W-1:0] out_seq
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] pending;
  logic [IDX_W-1:0] seq;
  logic             none_flag;
  logic [IDX_W-1:0] sel_idx;
  logic             one_left;
  logic             accept;
  logic             pop;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = EMIT;
      EMIT:    if (pop && out_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // All beat fields are gated by out_valid so the idle outputs read zero.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == EMIT);
    out_idx   = out_valid ? sel_idx : '0;
    out_last  = out_valid & (one_left | none_flag);
    out_none  = out_valid & none_flag;
    out_seq   = out_valid ? seq : '0;
  end

  always_comb begin
    sel_idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++)
        if (pending[i]) sel_idx = IDX_W'(i);
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--)
        if (pending[i]) sel_idx = IDX_W'(i);
    end
  end

  assign one_left = (pending != '0) && ((pending & (pending - WIDTH'(1))) == '0);

  // Sequence and none flag are cleared on the last pop so IDLE starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending   <= '0;
      seq       <= '0;
      none_flag <= 1'b0;
    end else if (accept) begin
      pending   <= in_vec;
      seq       <= '0;
      none_flag <= (in_vec == '0);
    end else if (pop) begin
      pending <= pending & ~(WIDTH'(1) << sel_idx);
      if (out_last) begin
        seq       <= '0;
        none_flag <= 1'b0;
      end else begin
        seq <= seq + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_prio_enc_stream.sv
// Scoreboard bench for prio_enc_stream: an MSB-first and an LSB-first instance
// driven with directed vectors; monitors compare every presented beat.
module tb_prio_enc_stream;

  typedef struct packed {
    logic [3:0] idx;
    logic       last;
    logic       none;
    logic [3:0] seq;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [15:0] a_in_vec;
  logic [3:0]  a_out_idx, a_out_seq;
  logic        a_out_last, a_out_none;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [15:0] b_in_vec;
  logic [3:0]  b_out_idx, b_out_seq;
  logic        b_out_last, b_out_none;

  beat_t exp_a[$];
  beat_t exp_b[$];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prio_enc_stream #(.WIDTH(16), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_vec(a_in_vec),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_idx(a_out_idx),
    .out_last(a_out_last), .out_none(a_out_none), .out_seq(a_out_seq)
  );

  prio_enc_stream #(.WIDTH(16), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_vec(b_in_vec),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_idx(b_out_idx),
    .out_last(b_out_last), .out_none(b_out_none), .out_seq(b_out_seq)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic pushExp(input bit on_b, input int idx, input bit last, input bit none, input int seq);
    beat_t e;
    e.idx  = 4'(idx);
    e.last = last;
    e.none = none;
    e.seq  = 4'(seq);
    if (on_b) exp_b.push_back(e);
    else      exp_a.push_back(e);
  endtask

  // Present one vector, hold in_valid until accepted, then check first-beat latency.
  task automatic applyStimulus(input bit on_b, input logic [15:0] vec);
    int n = 0;
    while (((on_b ? b_in_ready : a_in_ready) !== 1'b1) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) checkOutput("in_ready_timeout", 32'd0, 32'd1);
    if (on_b) begin b_in_vec = vec; b_in_valid = 1'b1; end
    else      begin a_in_vec = vec; a_in_valid = 1'b1; end
    @(posedge clk); #1;
    if (on_b) begin
      b_in_valid = 1'b0;
      checkOutput("first_beat_valid_b", 32'(b_out_valid), 32'd1);
      checkOutput("busy_in_ready_b", 32'(b_in_ready), 32'd0);
    end else begin
      a_in_valid = 1'b0;
      checkOutput("first_beat_valid_a", 32'(a_out_valid), 32'd1);
      checkOutput("busy_in_ready_a", 32'(a_in_ready), 32'd0);
    end
  endtask

  // Wait until every expected beat has been consumed, then the block must be idle.
  task automatic waitDrain(input bit on_b, input string name);
    int n = 0;
    while ((on_b ? exp_b.size() : exp_a.size()) != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) begin
      checkOutput({name, "_drain_timeout"}, 32'd0, 32'd1);
    end else begin
      checkOutput({name, "_idle_in_ready"}, 32'(on_b ? b_in_ready : a_in_ready), 32'd1);
      checkOutput({name, "_idle_out_valid"}, 32'(on_b ? b_out_valid : a_out_valid), 32'd0);
    end
  endtask

  // Monitors: pop on an accepted beat, compare against the head while stalled.
  always @(negedge clk) begin
    if (!rst && a_out_valid) begin
      beat_t act;
      act = {a_out_idx, a_out_last, a_out_none, a_out_seq};
      if (exp_a.size() == 0) begin
        checks++; failures++;
        $display("[TB] FAIL unexpected_beat_a: got %0h expected none", act);
      end else if (a_out_ready) begin
        checkOutput("beat_a", 32'(act), 32'(exp_a.pop_front()));
      end else begin
        checkOutput("hold_a", 32'(act), 32'(exp_a[0]));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_out_valid) begin
      beat_t act;
      act = {b_out_idx, b_out_last, b_out_none, b_out_seq};
      if (exp_b.size() == 0) begin
        checks++; failures++;
        $display("[TB] FAIL unexpected_beat_b: got %0h expected none", act);
      end else if (b_out_ready) begin
        checkOutput("beat_b", 32'(act), 32'(exp_b.pop_front()));
      end else begin
        checkOutput("hold_b", 32'(act), 32'(exp_b[0]));
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_vec = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_vec = '0; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(a_in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(a_out_valid), 32'd0);
    checkOutput("rst_out_idx", 32'(a_out_idx), 32'd0);
    checkOutput("rst_out_last", 32'(a_out_last), 32'd0);
    checkOutput("rst_out_none", 32'(a_out_none), 32'd0);
    checkOutput("rst_out_seq", 32'(a_out_seq), 32'd0);
    checkOutput("rst_in_ready_b", 32'(b_in_ready), 32'd1);

    $display("[TB] two-bit vector 8001");
    pushExp(0, 15, 0, 0, 0);
    pushExp(0, 0, 1, 0, 1);
    applyStimulus(0, 16'h8001);
    waitDrain(0, "v8001");

    $display("[TB] all-zero vector");
    pushExp(0, 0, 1, 1, 0);
    applyStimulus(0, 16'h0000);
    waitDrain(0, "v0000");

    $display("[TB] all-ones vector");
    for (int i = 0; i < 16; i++) pushExp(0, 15 - i, (i == 15), 0, i);
    applyStimulus(0, 16'hFFFF);
    waitDrain(0, "vFFFF");

    $display("[TB] backpressure on first beat");
    a_out_ready = 1'b0;
    pushExp(0, 4, 0, 0, 0);
    pushExp(0, 2, 1, 0, 1);
    applyStimulus(0, 16'h0014);
    repeat (3) @(posedge clk);
    #1 a_out_ready = 1'b1;
    waitDrain(0, "v0014_bp");

    $display("[TB] lsb-first instance");
    pushExp(1, 2, 0, 0, 0);
    pushExp(1, 4, 1, 0, 1);
    applyStimulus(1, 16'h0014);
    waitDrain(1, "lsb_v0014");
    pushExp(1, 0, 0, 0, 0);
    pushExp(1, 15, 1, 0, 1);
    applyStimulus(1, 16'h8001);
    waitDrain(1, "lsb_v8001");

    $display("[TB] reset mid-stream");
    pushExp(0, 7, 0, 0, 0);
    applyStimulus(0, 16'h00F0);
    n = 0;
    while (exp_a.size() != 0 && n < 50) begin
      @(posedge clk); n++;
    end
    if (n >= 50) checkOutput("mid_rst_pop_timeout", 32'd0, 32'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("mid_rst_out_valid", 32'(a_out_valid), 32'd0);
    checkOutput("mid_rst_out_seq", 32'(a_out_seq), 32'd0);
    checkOutput("mid_rst_out_idx", 32'(a_out_idx), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", 32'(a_in_ready), 32'd1);
    checkOutput("post_rst_out_valid", 32'(a_out_valid), 32'd0);
    pushExp(0, 1, 1, 0, 0);
    applyStimulus(0, 16'h0002);
    waitDrain(0, "post_rst_v0002");

    checkOutput("leftover_a", 32'(exp_a.size()), 32'd0);
    checkOutput("leftover_b", 32'(exp_b.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
